ddrx_refresh_timer: RTL and testbench

- Upstream of the address/command decoder.
- Generates periodic auto-refresh traffic: counts the tREFI interval, accumulates postponed refreshes, and arbitrates with the main command state machine over a req/gnt handshake.
- Drives the decoder's do_precharge_all, do_refresh and one-hot to_chip inputs.
- Holds rfsh_busy across tRP/tRFC so the main scheduler blocks other commands.

---
 rtl/ddrx_refresh_timer.sv | 228 ++++++++++++++++++++++
 tb/tb_ddrx_refresh_timer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddrx_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ddrx_refresh_timer
//  Purpose  : Periodic auto-refresh generator for a DDRx controller. Counts
//             the tREFI interval, accumulates owed refreshes up to the
//             postpone limit, and competes for the command bus with the main
//             scheduler over a req/gnt handshake. A granted round issues an
//             optional precharge-all, waits tRP, issues one auto-refresh and
//             waits tRFC while holding rfsh_busy.
//  Ports    :
//     ctl_clk           in   controller clock, rising edge
//     ctl_reset         in   asynchronous active-high reset
//     ctl_cal_success   in   calibration done; logic held cleared while low
//     cfg_trefi         in   refresh interval in cycles (0 treated as 1)
//     cfg_trp           in   precharge-to-refresh wait (0 treated as 1)
//     cfg_trfc          in   refresh-to-next-command wait (0 treated as 1)
//     bank_open         in   per chip: at least one bank open
//     rfsh_gnt          in   bus grant from the main state machine
//     rfsh_req          out  refresh pending, requesting the bus
//     rfsh_urgent       out  owed refreshes at the postpone limit
//     rfsh_busy         out  refresh sequence owns the bus
//     do_precharge_all  out  one-cycle precharge-all command
//     do_refresh        out  one-cycle auto-refresh command
//     to_chip           out  target chips (all ones during a command)
//     pending_cnt       out  refreshes owed
//  Revision : 1.0  initial release
// ============================================================================
module ddrx_refresh_timer #(
    parameter int MEM_IF_CS_WIDTH = 1,
    parameter int CNT_WIDTH       = 16,
    parameter int TMR_WIDTH       = 8,
    parameter int MAX_POSTPONE    = 8
) (
    input  logic                       ctl_clk,
    input  logic                       ctl_reset,
    input  logic                       ctl_cal_success,
    input  logic [CNT_WIDTH-1:0]       cfg_trefi,
    input  logic [TMR_WIDTH-1:0]       cfg_trp,
    input  logic [TMR_WIDTH-1:0]       cfg_trfc,
    input  logic [MEM_IF_CS_WIDTH-1:0] bank_open,
    input  logic                       rfsh_gnt,
    output logic                       rfsh_req,
    output logic                       rfsh_urgent,
    output logic                       rfsh_busy,
    output logic                       do_precharge_all,
    output logic                       do_refresh,
    output logic [MEM_IF_CS_WIDTH-1:0] to_chip,
    output logic [3:0]                 pending_cnt
);

    localparam logic [3:0] c_MAX_PEND = 4'(MAX_POSTPONE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_PCH      = 3'd2,
        ST_WAIT_RP  = 3'd3,
        ST_REF      = 3'd4,
        ST_WAIT_RFC = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Reload values. A programmed 0 behaves like 1 so the timers can never
    // wrap around to their maximum.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] w_trefi_m1;
    logic [TMR_WIDTH-1:0] w_trp_m1;
    logic [TMR_WIDTH-1:0] w_trfc_m1;

    assign w_trefi_m1 = (cfg_trefi == '0) ? '0 : cfg_trefi - CNT_WIDTH'(1);
    assign w_trp_m1   = (cfg_trp   == '0) ? '0 : cfg_trp   - TMR_WIDTH'(1);
    assign w_trfc_m1  = (cfg_trfc  == '0) ? '0 : cfg_trfc  - TMR_WIDTH'(1);

    // ------------------------------------------------------------------
    // Free-running tREFI interval counter. r_started marks that the first
    // calibrated cycle has loaded the interval; it is cleared whenever
    // calibration drops so the interval restarts in full afterwards.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_interval;
    logic                 r_started;
    logic                 w_tick;

    assign w_tick = r_started && (r_interval == '0);

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            r_interval <= '0;
            r_started  <= 1'b0;
        end else if (!ctl_cal_success) begin
            r_interval <= '0;
            r_started  <= 1'b0;
        end else if (!r_started) begin
            r_interval <= w_trefi_m1;
            r_started  <= 1'b1;
        end else if (w_tick) begin
            r_interval <= w_trefi_m1;
        end else begin
            r_interval <= r_interval - CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Owed-refresh accumulator. The decrement happens during the cycle the
    // refresh command is on the bus. A tick and a decrement in the same
    // cycle cancel; the sum is clamped so ticks at the limit are dropped.
    // REF is only reachable with at least one refresh owed, so the
    // subtraction cannot underflow.
    // ------------------------------------------------------------------
    state_t     r_state;
    logic       w_dec;
    logic [4:0] w_pend_sum;
    logic [3:0] w_pend_next;

    assign w_dec = (r_state == ST_REF);

    always_comb begin
        w_pend_sum  = {1'b0, pending_cnt} + {4'd0, w_tick} - {4'd0, w_dec};
        w_pend_next = w_pend_sum[3:0];
        if (w_pend_sum > {1'b0, c_MAX_PEND}) begin
            w_pend_next = c_MAX_PEND;
        end
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            pending_cnt <= 4'd0;
            rfsh_urgent <= 1'b0;
        end else if (!ctl_cal_success) begin
            pending_cnt <= 4'd0;
            rfsh_urgent <= 1'b0;
        end else begin
            pending_cnt <= w_pend_next;
            rfsh_urgent <= (w_pend_next == c_MAX_PEND);
        end
    end

    // ------------------------------------------------------------------
    // Refresh sequencer. Outputs are registered together with the state
    // they belong to, so each output is set on the transition into its
    // state. The wait timer is loaded on entry to PCH/REF and counts in
    // those states too, which places the refresh exactly tRP cycles after
    // the precharge and the return to IDLE exactly tRFC cycles after the
    // refresh. A wait of one cycle therefore skips the WAIT_* state.
    // ------------------------------------------------------------------
    logic [TMR_WIDTH-1:0] r_timer;

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            rfsh_req         <= 1'b0;
            rfsh_busy        <= 1'b0;
            do_precharge_all <= 1'b0;
            do_refresh       <= 1'b0;
            to_chip          <= '0;
        end else if (!ctl_cal_success) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            rfsh_req         <= 1'b0;
            rfsh_busy        <= 1'b0;
            do_precharge_all <= 1'b0;
            do_refresh       <= 1'b0;
            to_chip          <= '0;
        end else begin
            rfsh_req         <= 1'b0;
            rfsh_busy        <= 1'b0;
            do_precharge_all <= 1'b0;
            do_refresh       <= 1'b0;
            to_chip          <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (pending_cnt != 4'd0) begin
                        r_state  <= ST_REQ;
                        rfsh_req <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (rfsh_gnt) begin
                        rfsh_busy <= 1'b1;
                        to_chip   <= '1;
                        if (|bank_open) begin
                            r_state          <= ST_PCH;
                            do_precharge_all <= 1'b1;
                            r_timer          <= w_trp_m1;
                        end else begin
                            r_state    <= ST_REF;
                            do_refresh <= 1'b1;
                            r_timer    <= w_trfc_m1;
                        end
                    end else begin
                        rfsh_req <= 1'b1;
                    end
                end

                ST_PCH, ST_WAIT_RP: begin
                    rfsh_busy <= 1'b1;
                    if (r_timer == '0) begin
                        r_state    <= ST_REF;
                        do_refresh <= 1'b1;
                        to_chip    <= '1;
                        r_timer    <= w_trfc_m1;
                    end else begin
                        r_state <= ST_WAIT_RP;
                        r_timer <= r_timer - TMR_WIDTH'(1);
                    end
                end

                ST_REF, ST_WAIT_RFC: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state   <= ST_WAIT_RFC;
                        rfsh_busy <= 1'b1;
                        r_timer   <= r_timer - TMR_WIDTH'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddrx_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddrx_refresh_timer
//  Purpose  : Self-checking bench for ddrx_refresh_timer. A schedule-based
//             reference model (absolute tick times, grant times and
//             command times) predicts every output each cycle; directed
//             scenarios add latency and count checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddrx_refresh_timer;

    localparam int CS    = 2;
    localparam int CNT_W = 16;
    localparam int TMR_W = 8;
    localparam int MAXP  = 8;

    logic             ctl_clk = 1'b0;
    logic             ctl_reset;
    logic             ctl_cal_success;
    logic [CNT_W-1:0] cfg_trefi;
    logic [TMR_W-1:0] cfg_trp;
    logic [TMR_W-1:0] cfg_trfc;
    logic [CS-1:0]    bank_open;
    logic             rfsh_gnt;
    logic             rfsh_req;
    logic             rfsh_urgent;
    logic             rfsh_busy;
    logic             do_precharge_all;
    logic             do_refresh;
    logic [CS-1:0]    to_chip;
    logic [3:0]       pending_cnt;

    always #5 ctl_clk = ~ctl_clk;

    ddrx_refresh_timer #(
        .MEM_IF_CS_WIDTH (CS),
        .CNT_WIDTH       (CNT_W),
        .TMR_WIDTH       (TMR_W),
        .MAX_POSTPONE    (MAXP)
    ) u_dut (
        .ctl_clk          (ctl_clk),
        .ctl_reset        (ctl_reset),
        .ctl_cal_success  (ctl_cal_success),
        .cfg_trefi        (cfg_trefi),
        .cfg_trp          (cfg_trp),
        .cfg_trfc         (cfg_trfc),
        .bank_open        (bank_open),
        .rfsh_gnt         (rfsh_gnt),
        .rfsh_req         (rfsh_req),
        .rfsh_urgent      (rfsh_urgent),
        .rfsh_busy        (rfsh_busy),
        .do_precharge_all (do_precharge_all),
        .do_refresh       (do_refresh),
        .to_chip          (to_chip),
        .pending_cnt      (pending_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase 0 = idle, 1 = requesting, 2 = sequence running.
    // A sequence is described by its grant edge, refresh edge and idle edge.
    bit m_started;
    int m_tick_at;
    int m_pend;
    int m_phase;
    int m_g;
    int m_ref_e;
    int m_idle_e;
    bit m_pch;

    int first_req, first_ref, n_ref, n_pulse, pch_k, ref_k, busy_n, idle_k, bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_tick_at = 0;
        m_pend    = 0;
        m_phase   = 0;
        m_g       = -100;
        m_ref_e   = -100;
        m_idle_e  = -100;
        m_pch     = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs held
    // during the cycle that just ended.
    task automatic model_edge();
        int tick;
        int dec;
        if (!ctl_cal_success) begin
            model_reset();
            return;
        end
        tick = 0;
        if (!m_started) begin
            m_started = 1'b1;
            m_tick_at = cyc + eff(int'(cfg_trefi));
        end else if (cyc == m_tick_at) begin
            tick      = 1;
            m_tick_at = cyc + eff(int'(cfg_trefi));
        end
        // The owed count drops at the end of the cycle the refresh was shown.
        dec = (m_phase == 2 && cyc == m_ref_e + 1) ? 1 : 0;
        case (m_phase)
            0: if (m_pend > 0) m_phase = 1;
            1: if (rfsh_gnt) begin
                   m_phase  = 2;
                   m_g      = cyc;
                   m_pch    = |bank_open;
                   m_ref_e  = m_pch ? cyc + eff(int'(cfg_trp)) : cyc;
                   m_idle_e = m_ref_e + eff(int'(cfg_trfc));
               end
            default: if (cyc == m_idle_e) m_phase = 0;
        endcase
        m_pend = m_pend - dec + tick;
        if (m_pend > MAXP) m_pend = MAXP;
    endtask

    task automatic compare_all();
        logic [CS-1:0] ones;
        bit e_pch;
        bit e_ref;
        ones  = '1;
        e_pch = (m_phase == 2) && m_pch && (cyc == m_g);
        e_ref = (m_phase == 2) && (cyc == m_ref_e);
        check_val("rfsh_req",    rfsh_req,         m_phase == 1);
        check_val("rfsh_busy",   rfsh_busy,        m_phase == 2);
        check_val("do_pch_all",  do_precharge_all, e_pch);
        check_val("do_refresh",  do_refresh,       e_ref);
        check_val("to_chip",     to_chip,          (e_pch || e_ref) ? 32'(ones) : 32'd0);
        check_val("pending_cnt", pending_cnt,      m_pend);
        check_val("rfsh_urgent", rfsh_urgent,      m_pend == MAXP);
    endtask

    task automatic step();
        @(posedge ctl_clk);
        cyc++;
        if (ctl_reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        ctl_reset       = 1'b1;
        ctl_cal_success = 1'b0;
        cfg_trefi       = 16'd100;
        cfg_trp         = 8'd4;
        cfg_trfc        = 8'd20;
        bank_open       = '0;
        rfsh_gnt        = 1'b0;
        model_reset();

        // Reset and pre-calibration: everything quiet.
        repeat (3) step();
        ctl_reset = 1'b0;
        repeat (2) step();

        // Interval latency with grant tied high, no banks open.
        ctl_cal_success = 1'b1;
        rfsh_gnt        = 1'b1;
        first_req = -1; first_ref = -1; n_ref = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (rfsh_req && first_req < 0) first_req = k;
            if (do_refresh && first_ref < 0) first_ref = k;
            if (do_refresh) n_ref++;
        end
        check_val("s1_req_latency", first_req - 1, 101);
        check_val("s1_ref_latency", first_ref - 1, 102);
        check_val("s1_ref_count", n_ref, 1);
        check_val("s1_pending_end", pending_cnt, 0);

        // Precharge path with a single-cycle grant.
        rfsh_gnt  = 1'b0;
        bank_open = 2'b01;
        for (int i = 0; i < 250 && !rfsh_req; i++) step();
        check_val("s2_req_seen", rfsh_req, 1);
        pch_k = -1; ref_k = -1; busy_n = 0; idle_k = -1;
        rfsh_gnt = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            rfsh_gnt = 1'b0;
            if (do_precharge_all) pch_k = k;
            if (do_refresh) ref_k = k;
            if (rfsh_busy) busy_n++;
            if (!rfsh_busy && idle_k < 0) idle_k = k;
        end
        check_val("s2_pch_at", pch_k, 0);
        check_val("s2_ref_at", ref_k, 4);
        check_val("s2_busy_len", busy_n, 24);
        check_val("s2_idle_at", idle_k, 24);

        // Saturation of owed refreshes without grants.
        bank_open       = '0;
        cfg_trefi       = 16'd10;
        ctl_cal_success = 1'b0;
        step();
        ctl_cal_success = 1'b1;
        n_pulse = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (do_refresh || do_precharge_all) n_pulse++;
        end
        check_val("s3_pending_sat", pending_cnt, MAXP);
        check_val("s3_urgent", rfsh_urgent, 1);
        check_val("s3_no_cmds", n_pulse, 0);

        // Drain all owed refreshes, one per grant.
        cfg_trefi = 16'd60000;
        repeat (12) step();
        rfsh_gnt = 1'b1;
        n_ref = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (do_refresh) n_ref++;
        end
        check_val("s4_ref_count", n_ref, 8);
        check_val("s4_pending_zero", pending_cnt, 0);
        check_val("s4_urgent_clear", rfsh_urgent, 0);

        // Tick coincides with every refresh decrement: count holds at 1.
        ctl_cal_success = 1'b0;
        cfg_trefi       = 16'd3;
        cfg_trfc        = 8'd1;
        step();
        ctl_cal_success = 1'b1;
        bad = 0; n_ref = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k >= 4 && pending_cnt != 4'd1) bad++;
            if (do_refresh) n_ref++;
        end
        check_val("s5_pending_held", bad, 0);
        check_val("s5_ref_count", n_ref, 12);

        // Calibration dropped during WAIT_RFC, then restored.
        ctl_cal_success = 1'b0;
        cfg_trefi       = 16'd100;
        cfg_trfc        = 8'd20;
        step();
        ctl_cal_success = 1'b1;
        for (int i = 0; i < 150 && !do_refresh; i++) step();
        check_val("s6_ref_seen", do_refresh, 1);
        repeat (3) step();
        check_val("s6_busy_before", rfsh_busy, 1);
        ctl_cal_success = 1'b0;
        step();
        check_val("s6_busy_drop", rfsh_busy, 0);
        check_val("s6_pending_drop", pending_cnt, 0);
        ctl_cal_success = 1'b1;
        first_req = -1;
        for (int k = 1; k <= 110 && first_req < 0; k++) begin
            step();
            if (rfsh_req) first_req = k;
        end
        check_val("s6_req_restart", first_req - 1, 101);

        // Asynchronous reset in the middle of WAIT_RP.
        ctl_cal_success = 1'b0;
        cfg_trefi       = 16'd5;
        cfg_trp         = 8'd20;
        cfg_trfc        = 8'd4;
        bank_open       = '1;
        rfsh_gnt        = 1'b1;
        step();
        ctl_cal_success = 1'b1;
        for (int i = 0; i < 50 && !do_precharge_all; i++) step();
        check_val("s7_pch_seen", do_precharge_all, 1);
        repeat (3) step();
        #4;
        ctl_reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check_val("s7_async_busy", rfsh_busy, 0);
        n_ref = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (do_refresh) n_ref++;
        end
        check_val("s7_no_refresh", n_ref, 0);
        ctl_reset = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rfsh_gnt  = 1'($urandom_range(1, 0));
            bank_open = CS'($urandom_range(3, 0));
            if ($urandom_range(39, 0) == 0) cfg_trefi = 16'($urandom_range(30, 0));
            if ($urandom_range(299, 0) == 0) begin
                ctl_cal_success = 1'b0;
                cfg_trp  = 8'($urandom_range(12, 0));
                cfg_trfc = 8'($urandom_range(12, 0));
                repeat ($urandom_range(3, 1)) step();
                ctl_cal_success = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
